// File: rtl/ws2812_frame_decoder_if.sv
// Frame bus between a WS2812 line decoder and its consumer.
// The decoder takes the master side: it reads the line and drives the decoded frame.
`timescale 1ns/1ps
interface ws2812_frame_decoder_if #(
  parameter int NUM_LEDS = 10
);
  localparam int FRAME_BITS = NUM_LEDS * 24;

  logic                  din;
  logic [FRAME_BITS-1:0] data_out;
  logic                  frame_valid;
  logic                  overrun;
  logic                  err;
  logic                  busy;

  modport master (
    input  din,
    output data_out, frame_valid, overrun, err, busy
  );

  modport slave (
    output din,
    input  data_out, frame_valid, overrun, err, busy
  );
endinterface

// File: rtl/ws2812_frame_decoder.sv
// WS2812 NRZ receiver: classifies high-pulse widths into bits and latches a
// complete frame onto data_out when a long low gap terminates it.
`timescale 1ns/1ps
module ws2812_frame_decoder #(
  parameter int NUM_LEDS   = 10,
  parameter int MIN_HIGH   = 3,
  parameter int THRESH     = 12,
  parameter int MAX_HIGH   = 30,
  parameter int RESET_CLKS = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  ws2812_frame_decoder_if.master bus
);
  localparam int FRAME_BITS = NUM_LEDS * 24;
  localparam int HCNT_W     = $clog2(MAX_HIGH + 2);
  localparam int LCNT_W     = $clog2(RESET_CLKS + 1);
  localparam int BITS_W     = $clog2(FRAME_BITS + 2);

  localparam logic [HCNT_W-1:0] H_ONE  = HCNT_W'(1);
  localparam logic [HCNT_W-1:0] H_MIN  = HCNT_W'(MIN_HIGH);
  localparam logic [HCNT_W-1:0] H_THR  = HCNT_W'(THRESH);
  localparam logic [HCNT_W-1:0] H_MAX  = HCNT_W'(MAX_HIGH);
  localparam logic [HCNT_W-1:0] H_SAT  = HCNT_W'(MAX_HIGH + 1);
  localparam logic [LCNT_W-1:0] L_ONE  = LCNT_W'(1);
  localparam logic [LCNT_W-1:0] L_LAST = LCNT_W'(RESET_CLKS - 1);
  localparam logic [BITS_W-1:0] B_FULL = BITS_W'(FRAME_BITS);
  localparam logic [BITS_W-1:0] B_SAT  = BITS_W'(FRAME_BITS + 1);

  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW, S_ERR} state_e;

  function automatic logic [HCNT_W-1:0] hcnt_inc(input logic [HCNT_W-1:0] c);
    return (c >= H_SAT) ? H_SAT : c + H_ONE;
  endfunction

  function automatic logic [BITS_W-1:0] bits_inc(input logic [BITS_W-1:0] c);
    return (c >= B_SAT) ? B_SAT : c + BITS_W'(1);
  endfunction

  logic                  din_meta_q, din_s_q;
  state_e                state_q, state_d;
  logic [HCNT_W-1:0]     hcnt_q, hcnt_d;
  logic [LCNT_W-1:0]     lcnt_q, lcnt_d;
  logic [BITS_W-1:0]     bits_q, bits_d;
  logic                  ovr_q, ovr_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] dout_q, dout_d;
  logic                  fv_q, fv_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;
  logic                  busy;

  // Stage p0/p1: two-flop synchroniser for the asynchronous line, then state update
  always_ff @(posedge clk) begin
    din_meta_q <= bus.din;
    din_s_q    <= din_meta_q;
    shift_q    <= shift_d;
    if (reset) begin
      state_q <= S_SYNC;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      bits_q  <= '0;
      ovr_q   <= 1'b0;
      dout_q  <= '0;
      fv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      bits_q  <= bits_d;
      ovr_q   <= ovr_d;
      dout_q  <= dout_d;
      fv_q    <= fv_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    bits_d  = bits_q;
    ovr_d   = ovr_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    fv_d    = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_SYNC, S_ERR: begin
        if (din_s_q) begin
          lcnt_d = '0;
        end else if (lcnt_q == L_LAST) begin
          lcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          lcnt_d = lcnt_q + L_ONE;
        end
      end
      S_IDLE: begin
        shift_d = '0;
        bits_d  = '0;
        ovr_d   = 1'b0;
        if (din_s_q) begin
          hcnt_d  = H_ONE;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (din_s_q) begin
          hcnt_d = hcnt_inc(hcnt_q);
          if (hcnt_q >= H_MAX) begin
            err_d   = 1'b1;
            lcnt_d  = '0;
            state_d = S_ERR;
          end
        end else if (hcnt_q < H_MIN) begin
          // The falling cycle is itself low, so it opens the recovery gap count
          err_d   = 1'b1;
          lcnt_d  = L_ONE;
          state_d = S_ERR;
        end else begin
          if (bits_q < B_FULL) begin
            shift_d = {shift_q[FRAME_BITS-2:0], (hcnt_q >= H_THR)};
          end else begin
            ovr_d = 1'b1;
          end
          bits_d  = bits_inc(bits_q);
          lcnt_d  = L_ONE;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (din_s_q) begin
          hcnt_d  = H_ONE;
          state_d = S_HIGH;
        end else if (lcnt_q == L_LAST) begin
          lcnt_d  = '0;
          state_d = S_IDLE;
          if (bits_q >= B_FULL) begin
            dout_d = shift_q;
            fv_d   = 1'b1;
            ovf_d  = ovr_q;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          lcnt_d = lcnt_q + L_ONE;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if ((state_q == S_HIGH || state_q == S_LOW) && bits_q != '0) begin
      busy = 1'b1;
    end
  end

  assign bus.data_out    = dout_q;
  assign bus.frame_valid = fv_q;
  assign bus.overrun     = ovf_q;
  assign bus.err         = err_q;
  assign bus.busy        = busy;
endmodule

// File: tb/tb_ws2812_frame_decoder.sv
// Directed-random bench for ws2812_frame_decoder: pulse trains are built as
// width lists and the expected outcome of each frame is derived from those lists.
`timescale 1ns/1ps
module tb_ws2812_frame_decoder;
  localparam int NL   = 10;
  localparam int FB   = NL * 24;
  localparam int MINH = 3;
  localparam int TH   = 12;
  localparam int MAXH = 30;
  localparam int RC   = 1000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ws2812_frame_decoder_if #(.NUM_LEDS(NL)) bus ();

  ws2812_frame_decoder #(
    .NUM_LEDS(NL), .MIN_HIGH(MINH), .THRESH(TH), .MAX_HIGH(MAXH), .RESET_CLKS(RC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge
  int            fv_cnt = 0, err_cnt = 0, both_cnt = 0, ovr_stray = 0, fv_cyc = 0;
  logic          ovr_at_fv = 1'b0;
  always @(negedge clk) begin
    if (bus.frame_valid) begin
      fv_cnt++;
      fv_cyc    = cyc;
      ovr_at_fv = bus.overrun;
    end
    if (bus.err) err_cnt++;
    if (bus.frame_valid && bus.err) both_cnt++;
    if (bus.overrun && !bus.frame_valid) ovr_stray++;
  end

  int            n_cmp = 0, n_bad = 0;
  int            hq[$];
  int            lq[$];
  bit            armed = 1'b0;
  logic [FB-1:0] exp_dout = '0;
  int            last_fall = 0;

  task automatic chk_v(input string tag, input logic [FB-1:0] obs, input logic [FB-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [FB-1:0] rnd_frame();
    logic [FB-1:0] d;
    for (int i = 0; i < FB; i++) d[i] = 1'($urandom_range(1, 0));
    return d;
  endfunction

  task automatic add_pulse(input int h, input int l);
    hq.push_back(h);
    lq.push_back(l);
  endtask

  task automatic add_bit(input logic b);
    int h;
    if (b) h = int'($urandom_range(MAXH, TH));
    else   h = int'($urandom_range(TH - 1, MINH));
    add_pulse(h, int'($urandom_range(4, 1)));
  endtask

  task automatic add_bits(input logic [FB-1:0] d, input int n);
    for (int i = 0; i < n; i++) add_bit(d[FB-1-i]);
  endtask

  task automatic drive_bits();
    for (int i = 0; i < hq.size(); i++) begin
      bus.din = 1'b1;
      repeat (hq[i]) @(negedge clk);
      bus.din   = 1'b0;
      last_fall = cyc + 1;
      repeat (lq[i]) @(negedge clk);
    end
  endtask

  // Drive the queued pulses plus a terminating gap, then compare against the
  // outcome implied by the pulse widths alone.
  task automatic run_frame(input string tag);
    int   fv0, err0, efv, eerr;
    logic eovr;
    bit   bad;
    fv0  = fv_cnt;
    err0 = err_cnt;
    efv  = 0;
    eerr = 0;
    eovr = 1'b0;
    bad  = 1'b0;
    drive_bits();
    repeat (RC + 8) @(negedge clk);
    if (armed) begin
      foreach (hq[i]) if (hq[i] < MINH || hq[i] > MAXH) bad = 1'b1;
      if (bad || hq.size() < FB) begin
        eerr = 1;
      end else begin
        efv  = 1;
        eovr = (hq.size() > FB);
        for (int i = 0; i < FB; i++) exp_dout[FB-1-i] = (hq[i] >= TH);
      end
    end
    armed = 1'b1;
    chk_i({tag, "_fv"}, fv_cnt - fv0, efv);
    chk_i({tag, "_err"}, err_cnt - err0, eerr);
    if (efv == 1) chk_i({tag, "_ovr"}, int'(ovr_at_fv), int'(eovr));
    chk_v({tag, "_dout"}, bus.data_out, exp_dout);
    chk_i({tag, "_busy"}, int'(bus.busy), 0);
    hq.delete();
    lq.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_v({tag, "_dout"}, bus.data_out, '0);
    chk_i({tag, "_fv"}, int'(bus.frame_valid), 0);
    chk_i({tag, "_err"}, int'(bus.err), 0);
    chk_i({tag, "_ovr"}, int'(bus.overrun), 0);
    chk_i({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [FB-1:0] d;
    int            fv0, err0;
    bus.din = 1'b0;
    reset   = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;

    // No gap seen since reset: this frame must be ignored
    add_bits(rnd_frame(), FB);
    run_frame("nogap");

    // Loopback pattern, then latency from raw din
    d = {30{8'hA5}};
    add_bits(d, FB);
    run_frame("a5");
    chk_i("a5_lat", fv_cyc - last_fall, RC + 1);
    chk_v("a5_exact", bus.data_out, {30{8'hA5}});

    add_bits(rnd_frame(), FB);
    run_frame("b2b1");
    add_bits(rnd_frame(), FB);
    run_frame("b2b2");

    // Glitch mid-frame, then a clean frame
    d = rnd_frame();
    add_bits(d, 100);
    add_pulse(2, 3);
    add_bits(d, 139);
    run_frame("glitch");
    add_bits(rnd_frame(), FB);
    run_frame("post_glitch");

    // Stuck-high, further pulses (including another glitch) before the gap
    add_pulse(31, 5);
    add_bits(rnd_frame(), 50);
    add_pulse(1, 2);
    add_bits(rnd_frame(), 20);
    run_frame("stuck");

    // Threshold boundary widths on the first four bits of a clean frame
    d = rnd_frame();
    add_pulse(8, 3);
    add_pulse(11, 3);
    add_pulse(12, 3);
    add_pulse(16, 3);
    add_bits(d, FB - 4);
    run_frame("thr");
    chk_i("thr_msb4", int'(bus.data_out[FB-1 -: 4]), 3);

    // Short, long and gap-splitting frames
    add_bits(rnd_frame(), FB - 1);
    run_frame("short239");
    d = rnd_frame();
    add_bits(d, FB);
    add_bit(1'b1);
    run_frame("long241");
    chk_v("long241_keep", bus.data_out, d);
    d = rnd_frame();
    add_bits(d, FB / 2);
    lq[FB/2 - 1] = RC - 1;
    add_bits(d << (FB / 2), FB / 2);
    run_frame("gap999");
    chk_v("gap999_data", bus.data_out, d);

    // Reset in the middle of a frame
    add_bits(rnd_frame(), 100);
    drive_bits();
    hq.delete();
    lq.delete();
    chk_i("mid_busy", int'(bus.busy), 1);
    fv0   = fv_cnt;
    err0  = err_cnt;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("midrst");
    reset     = 1'b0;
    armed     = 1'b0;
    exp_dout  = '0;
    add_bits(rnd_frame(), FB);
    run_frame("rst_ign");
    chk_i("rst_ign_events", (fv_cnt - fv0) + (err_cnt - err0), 0);
    add_bits(rnd_frame(), FB);
    run_frame("rst_clean");

    chk_i("fv_err_same_cycle", both_cnt, 0);
    chk_i("overrun_outside_fv", ovr_stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
